dt_res_pack: RTL

- Inverse of the distance-transform stage: reads the 128x128 8-bit distance map from the res RAM and thresholds each pixel to 1 bit.
- Packs 16 pixels per 16-bit word and writes 1024 words to a packed-image RAM in the same format as the sti ROM.
- Sits after the DT core; the controller starts it once the DT core asserts done.
- With THRESH=1 the output reproduces the original binary image; the bench uses this as a round-trip check.

---
 rtl/dt_pkg.sv | 17 +
 rtl/dt_bit_packer.sv | 35 +++
 rtl/dt_res_pack.sv | 113 +++++++++++
 3 files changed

// File: rtl/dt_pkg.sv
// Shared constants and state type for the distance-transform pipeline.
// The DT core and the result packer both import this package.
package dt_pkg;

  localparam int IMG_W        = 128;
  localparam int NUM_PIX      = 16384;
  localparam int NUM_WORDS    = 1024;
  localparam int PIX_PER_WORD = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LAST = 2'd2,
    FIN  = 2'd3
  } dt_state_e;

endpackage

// File: rtl/dt_bit_packer.sv
// MSB-first serial-to-parallel packer: gathers 16 thresholded pixels into one word.
// o_word is the assembled word including the bit being shifted this cycle.
module dt_bit_packer
  import dt_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clear,
  input  logic                    i_shift,
  input  logic                    i_bit,
  output logic [PIX_PER_WORD-1:0] o_word,
  output logic                    o_word_valid
);

  // Only the 15 older bits need storage; the 16th arrives on i_bit.
  logic [PIX_PER_WORD-2:0] r_sr;
  logic [3:0]              r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_sr    <= '0;
      r_count <= '0;
    end else if (i_shift) begin
      r_sr    <= {r_sr[PIX_PER_WORD-3:0], i_bit};
      r_count <= r_count + 4'd1;
    end
  end

  assign o_word       = {r_sr, i_bit};
  assign o_word_valid = i_shift && (r_count == 4'hF);

endmodule

// File: rtl/dt_res_pack.sv
// Reads the 8-bit distance map, thresholds each pixel and writes 16-pixel
// packed words (bit 15 = lowest pixel address) to the packed-image RAM.
module dt_res_pack
  import dt_pkg::*;
#(
  parameter int PIX_W       = 8,
  parameter int ADDR_W      = 14,
  parameter int WORD_ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [PIX_W-1:0]        threshold,
  output logic                    busy,
  output logic                    done,
  output logic                    res_rd,
  output logic [ADDR_W-1:0]       res_addr,
  input  logic [PIX_W-1:0]        res_di,
  output logic                    pk_wr,
  output logic [WORD_ADDR_W-1:0]  pk_addr,
  output logic [PIX_PER_WORD-1:0] pk_do
);

  dt_state_e                r_state;
  logic [PIX_W-1:0]         r_thr;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_res_rd;
  logic [ADDR_W-1:0]        r_res_addr;
  logic                     r_pk_wr;
  logic [WORD_ADDR_W-1:0]   r_pk_addr;
  logic [PIX_PER_WORD-1:0]  r_pk_do;

  logic                     w_start_ok;
  logic                     w_shift;
  logic                     w_bit;
  logic                     w_last_pix;
  logic [PIX_PER_WORD-1:0]  w_word;
  logic                     w_word_valid;

  // A start is honoured only when no frame is in flight.
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == FIN));
  assign w_shift    = (r_state == READ);
  assign w_bit      = (res_di >= r_thr);
  assign w_last_pix = (r_res_addr == ADDR_W'(NUM_PIX - 1));

  dt_bit_packer u_packer (
    .i_clk        (clk),
    .i_rst_n      (reset),
    .i_clear      (w_start_ok),
    .i_shift      (w_shift),
    .i_bit        (w_bit),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_thr      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_res_rd   <= 1'b0;
      r_res_addr <= '0;
      r_pk_wr    <= 1'b0;
      r_pk_addr  <= '0;
      r_pk_do    <= '0;
    end else begin
      r_pk_wr <= 1'b0;
      case (r_state)
        IDLE, FIN: begin
          if (start) begin
            r_thr      <= threshold;
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
            r_res_rd   <= 1'b1;
            r_res_addr <= '0;
            r_state    <= READ;
          end
        end
        READ: begin
          // Word address is fixed by the upper address bits of the current pixel.
          if (w_word_valid) begin
            r_pk_do   <= w_word;
            r_pk_addr <= WORD_ADDR_W'(r_res_addr >> 4);
            r_pk_wr   <= 1'b1;
          end
          if (w_last_pix) begin
            r_res_rd <= 1'b0;
            r_state  <= LAST;
          end else begin
            r_res_addr <= r_res_addr + 1'b1;
          end
        end
        LAST: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= FIN;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign res_rd   = r_res_rd;
  assign res_addr = r_res_addr;
  assign pk_wr    = r_pk_wr;
  assign pk_addr  = r_pk_addr;
  assign pk_do    = r_pk_do;

endmodule
